// File: rtl/port_deframer.sv
// port_deframer
//   Consumer for one switch output port. Pops bytes from the port FIFO through
//   a 1-cycle-latency ready/read handshake into a 2-entry skid buffer, parses
//   the DA, SA, LEN, payload, FCS framing as bytes enter the buffer, and
//   streams them out with valid/ready backpressure. Reports per-packet status
//   when the FCS byte is accepted downstream.
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   ready / read / port_data    port FIFO side (data valid 1 cycle after read)
//   out_data/valid/ready        byte stream; out_sop on DA, out_eop on FCS
//   pkt_done, fcs_err           1-cycle status pulse and FCS mismatch flag
//   pkt_da, pkt_len             DA/LEN of last completed packet
//   pkt_count, err_count        saturating packet / FCS-error counters
module port_deframer #(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ready,
    output logic             read,
    input  logic [DW-1:0]    port_data,
    output logic [DW-1:0]    out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sop,
    output logic             out_eop,
    output logic             pkt_done,
    output logic [DW-1:0]    pkt_da,
    output logic [DW-1:0]    pkt_len,
    output logic             fcs_err,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {S_DA, S_SA, S_LEN, S_PAY, S_FCS} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_rem;
    logic [DW-1:0]   w_rem_nxt;
    logic [DW-1:0]   r_xor;
    logic [DW-1:0]   w_xor_nxt;
    logic [DW-1:0]   r_cur_da;
    logic [DW-1:0]   r_cur_len;
    logic [DW-1:0]   r_fin_da;
    logic [DW-1:0]   r_fin_len;
    logic            r_fin_err;

    // Skid buffer entries hold {sop, eop, data}; entry 0 is the head.
    logic [DW+1:0]   r_ent0;
    logic [DW+1:0]   r_ent1;
    logic [1:0]      r_cnt;
    logic            r_inflight;
    logic            w_push;
    logic            w_pop;
    logic [2:0]      w_level;
    logic [DW+1:0]   w_ent;

    assign out_valid = (r_cnt != 2'd0);
    assign out_sop   = r_ent0[DW+1];
    assign out_eop   = r_ent0[DW];
    assign out_data  = r_ent0[DW-1:0];

    assign w_push = r_inflight;
    assign w_pop  = out_valid & out_ready;
    assign w_ent  = {(r_state == S_DA), (r_state == S_FCS), port_data};

    // Occupancy after this edge's pop plus the byte already in flight. The
    // same-cycle pop is credited so a steady stream keeps 1 byte/cycle.
    assign w_level = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign read    = ready & ~reset & (w_level <= 3'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_DA;
            r_rem   <= '0;
            r_xor   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_xor   <= w_xor_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_xor_nxt   = r_xor;
        if (w_push) begin
            w_xor_nxt = r_xor ^ port_data;
            unique case (r_state)
                S_DA: begin
                    w_xor_nxt   = port_data;
                    w_state_nxt = S_SA;
                end
                S_SA:  w_state_nxt = S_LEN;
                S_LEN: begin
                    w_rem_nxt   = port_data;
                    w_state_nxt = (port_data == '0) ? S_FCS : S_PAY;
                end
                S_PAY: begin
                    w_rem_nxt = r_rem - DW'(1);
                    if (r_rem == DW'(1)) w_state_nxt = S_FCS;
                end
                S_FCS:   w_state_nxt = S_DA;
                default: w_state_nxt = S_DA;
            endcase
        end
    end

    // Packet fields captured at parse time. A packet is at least 4 bytes and
    // the buffer holds 2, so the next FCS cannot be parsed before this one pops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur_da  <= '0;
            r_cur_len <= '0;
            r_fin_da  <= '0;
            r_fin_len <= '0;
            r_fin_err <= 1'b0;
        end else if (w_push) begin
            if (r_state == S_DA)  r_cur_da  <= port_data;
            if (r_state == S_LEN) r_cur_len <= port_data;
            if (r_state == S_FCS) begin
                r_fin_da  <= r_cur_da;
                r_fin_len <= r_cur_len;
                r_fin_err <= (r_xor != port_data);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight <= 1'b0;
            r_cnt      <= 2'd0;
            r_ent0     <= '0;
            r_ent1     <= '0;
        end else begin
            r_inflight <= read;
            unique case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_ent0 <= w_ent;
                    else               r_ent1 <= w_ent;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_ent0 <= r_ent1;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_ent0 <= w_ent;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= w_ent;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_done  <= 1'b0;
            fcs_err   <= 1'b0;
            pkt_da    <= '0;
            pkt_len   <= '0;
            pkt_count <= '0;
            err_count <= '0;
        end else begin
            pkt_done <= 1'b0;
            fcs_err  <= 1'b0;
            if (w_pop && out_eop) begin
                pkt_done <= 1'b1;
                fcs_err  <= r_fin_err;
                pkt_da   <= r_fin_da;
                pkt_len  <= r_fin_len;
                if (pkt_count != '1) pkt_count <= pkt_count + 1'b1;
                if (r_fin_err && (err_count != '1)) err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_port_deframer.sv
// tb_port_deframer
//   Directed bench for port_deframer: a queue-based port FIFO model feeds the
//   DUT, a negedge monitor captures accepted bytes and status pulses, and the
//   main sequence compares them against hand-computed packets.
module tb_port_deframer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready = 1'b0;
    logic        read;
    logic [7:0]  port_data = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;
    logic        pkt_done;
    logic [7:0]  pkt_da;
    logic [7:0]  pkt_len;
    logic        fcs_err;
    logic [15:0] pkt_count;
    logic [15:0] err_count;

    logic [7:0]  fifo_q[$];
    logic [9:0]  exp_q[$];
    logic [9:0]  cap_q[$];
    logic [16:0] st_q[$];

    int   checks   = 0;
    int   failures = 0;
    int   rd_cnt   = 0;
    int   rd0;
    logic gate     = 1'b1;
    logic toggle   = 1'b0;
    logic hold     = 1'b0;
    logic [9:0] held = '0;

    port_deframer #(.DW(8), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .ready     (ready),
        .read      (read),
        .port_data (port_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .pkt_done  (pkt_done),
        .pkt_da    (pkt_da),
        .pkt_len   (pkt_len),
        .fcs_err   (fcs_err),
        .pkt_count (pkt_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Port FIFO model: registered read data, one cycle after read.
    always @(posedge clk) begin
        if (read && fifo_q.size() != 0) port_data <= fifo_q.pop_front();
    end

    always @(negedge clk) begin
        if (read) begin
            rd_cnt++;
            check("read_only_when_ready", {31'd0, ready}, 1);
        end
        if (!pkt_done) check("fcs_err_without_done", {31'd0, fcs_err}, 0);
        if (hold) check("stall_stable", {21'd0, out_valid, out_sop, out_eop, out_data}, {21'd0, 1'b1, held});
        if (out_valid && out_ready) cap_q.push_back({out_sop, out_eop, out_data});
        if (pkt_done) st_q.push_back({fcs_err, pkt_da, pkt_len});
        hold = out_valid && !out_ready && !reset;
        held = {out_sop, out_eop, out_data};
        if (toggle) gate = ~gate;
        else        gate = 1'b1;
        ready = gate && (fifo_q.size() != 0);
    end

    task automatic push_pkt(input logic [127:0] v, input int n, input bit track);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = v[8*(n-1-i) +: 8];
            fifo_q.push_back(b);
            if (track) exp_q.push_back({(i == 0), (i == n-1), b});
        end
    endtask

    task automatic check_stream(input string tag);
        int t = 0;
        while (cap_q.size() < exp_q.size() && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        check({tag, "_count"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), {22'd0, cap_q[i]}, {22'd0, exp_q[i]});
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic expect_status(input string tag, input logic [7:0] da, input logic [7:0] len, input logic err);
        int t = 0;
        logic [16:0] s;
        while (st_q.size() == 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check({tag, "_done_seen"}, {31'd0, (st_q.size() != 0)}, 1);
        if (st_q.size() != 0) begin
            s = st_q.pop_front();
            check({tag, "_da"},  {24'd0, s[15:8]}, {24'd0, da});
            check({tag, "_len"}, {24'd0, s[7:0]},  {24'd0, len});
            check({tag, "_err"}, {31'd0, s[16]},   {31'd0, err});
        end
    endtask

    initial begin
        int t;
        reset     = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_read",      {31'd0, read}, 0);
        check("rst_pkt_done",  {31'd0, pkt_done}, 0);
        check("rst_pkt_count", {16'd0, pkt_count}, 0);
        check("rst_err_count", {16'd0, err_count}, 0);

        // 1: good LEN=2 packet
        @(posedge clk); #1;
        push_pkt({8'h01, 8'hAA, 8'h02, 8'h11, 8'h22, 8'h9A}, 6, 1'b1);
        check_stream("t1");
        expect_status("t1", 8'h01, 8'h02, 1'b0);
        check("t1_pkt_count", {16'd0, pkt_count}, 1);
        check("t1_err_count", {16'd0, err_count}, 0);

        // 2: same packet, bad FCS
        @(posedge clk); #1;
        push_pkt({8'h01, 8'hAA, 8'h02, 8'h11, 8'h22, 8'h9B}, 6, 1'b1);
        check_stream("t2");
        expect_status("t2", 8'h01, 8'h02, 1'b1);
        check("t2_pkt_count", {16'd0, pkt_count}, 2);
        check("t2_err_count", {16'd0, err_count}, 1);

        // 3: LEN=0
        @(posedge clk); #1;
        push_pkt({8'h02, 8'h55, 8'h00, 8'h57}, 4, 1'b1);
        check_stream("t3");
        expect_status("t3", 8'h02, 8'h00, 1'b0);
        check("t3_pkt_count", {16'd0, pkt_count}, 3);

        // 4: downstream stall of 10 cycles mid-payload
        @(posedge clk); #1;
        push_pkt({8'h03, 8'h10, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h13}, 8, 1'b1);
        t = 0;
        while (cap_q.size() < 4 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("t4_reached_payload", {31'd0, (cap_q.size() == 4)}, 1);
        #1 out_ready = 1'b0;
        rd0 = rd_cnt;
        repeat (10) @(posedge clk);
        #1;
        check("t4_reads_in_stall", {31'd0, ((rd_cnt - rd0) <= 2)}, 1);
        check("t4_valid_held",     {31'd0, out_valid}, 1);
        check("t4_read_stopped",   {31'd0, read}, 0);
        out_ready = 1'b1;
        check_stream("t4");
        expect_status("t4", 8'h03, 8'h04, 1'b0);
        check("t4_pkt_count", {16'd0, pkt_count}, 4);

        // 5: ready toggling over three back-to-back packets
        @(posedge clk); #1;
        toggle = 1'b1;
        push_pkt({8'h04, 8'h20, 8'h01, 8'h7E, 8'h5B}, 5, 1'b1);
        push_pkt({8'h05, 8'h21, 8'h00, 8'h24}, 4, 1'b1);
        push_pkt({8'h06, 8'h22, 8'h03, 8'h01, 8'h02, 8'h03, 8'h27}, 7, 1'b1);
        check_stream("t5");
        expect_status("t5a", 8'h04, 8'h01, 1'b0);
        expect_status("t5b", 8'h05, 8'h00, 1'b0);
        expect_status("t5c", 8'h06, 8'h03, 1'b0);
        check("t5_pkt_count", {16'd0, pkt_count}, 7);
        check("t5_err_count", {16'd0, err_count}, 1);
        @(posedge clk); #1;
        toggle = 1'b0;

        // 6: reset during payload byte 3 of a LEN=5 packet
        push_pkt({8'h07, 8'h30, 8'h05, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'h00}, 9, 1'b0);
        t = 0;
        while (cap_q.size() < 6 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("t6_reached_pay3", {31'd0, (cap_q.size() == 6)}, 1);
        #1 reset = 1'b1;
        #1;
        check("t6_rst_valid",     {31'd0, out_valid}, 0);
        check("t6_rst_read",      {31'd0, read}, 0);
        check("t6_rst_pkt_done",  {31'd0, pkt_done}, 0);
        check("t6_rst_pkt_count", {16'd0, pkt_count}, 0);
        check("t6_rst_err_count", {16'd0, err_count}, 0);
        check("t6_rst_out_data",  {24'd0, out_data}, 0);
        fifo_q.delete();
        cap_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("t6_no_partial_done", st_q.size(), 0);
        @(posedge clk); #1;
        push_pkt({8'h08, 8'h40, 8'h01, 8'h99, 8'hD0}, 5, 1'b1);
        check_stream("t6");
        expect_status("t6", 8'h08, 8'h01, 1'b0);
        repeat (10) @(posedge clk);
        check("t6_single_done", st_q.size(), 0);
        check("t6_pkt_count", {16'd0, pkt_count}, 1);
        check("t6_err_count", {16'd0, err_count}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
